// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch requests, PC+4 advance, branch/jump redirect with flush.
// Latency: PC advances 1 cycle after ack; a redirect target is on if_addr 1 cycle later and fetched 2 cycles later.
// Backpressure: stall or a missing if_ack holds the PC; redirects are taken regardless of either.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    output logic [31:0] pc4_out,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    output logic        flush
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        br_hit;
    logic        redirect;
    logic        flush_nxt;

    assign pc4        = pc + 32'd4;
    assign br_target  = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign jmp_target = {pc4[31:28], jmp_index, 2'b00};
    assign br_hit     = br_valid & br_taken;
    assign redirect   = br_hit | jmp_valid;

    assign if_addr = pc;
    assign pc4_out = pc4;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        flush_nxt = 1'b0;
        if_req    = 1'b0;
        case (state)
            INIT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if_req = ~stall;
                if (~stall & if_ack) begin
                    pc_nxt = pc4;
                end
            end
            REDIRECT: begin
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        // The branch is the older instruction, so it wins over a same-cycle jump.
        if ((state == FETCH || state == REDIRECT) && redirect) begin
            pc_nxt    = br_hit ? br_target : jmp_target;
            flush_nxt = 1'b1;
            state_nxt = REDIRECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            flush <= flush_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expected PC, if_req and flush values.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] pc4_out;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic        jmp_valid;
    logic [25:0] jmp_index;
    logic        flush;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .pc4_out   (pc4_out),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_pc4    (br_pc4),
        .br_imm    (br_imm),
        .jmp_valid (jmp_valid),
        .jmp_index (jmp_index),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_pc4    = 32'h0;
        br_imm    = 16'h0;
        jmp_valid = 1'b0;
        jmp_index = 26'h0;
    endtask

    task automatic take_branch(input logic [31:0] pc4_v, input logic [15:0] imm_v);
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_pc4   = pc4_v;
        br_imm   = imm_v;
    endtask

    initial begin
        rst_n  = 1'b0;
        stall  = 1'b0;
        if_ack = 1'b1;
        clear_redirects();
        #2;
        check("rst_addr", if_addr, 32'h0);
        check("rst_req", {31'h0, if_req}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);

        // Reset release with ack every cycle: INIT cycle, then 0,4,8,C.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_req", {31'h0, if_req}, 32'h0);
        check("init_addr", if_addr, 32'h0);
        step();
        check("f0_addr", if_addr, 32'h0);
        check("f0_req", {31'h0, if_req}, 32'h1);
        step();
        check("f1_addr", if_addr, 32'h4);
        step();
        check("f2_addr", if_addr, 32'h8);
        step();
        check("f3_addr", if_addr, 32'hC);
        check("f3_req", {31'h0, if_req}, 32'h1);
        check("f3_pc4", pc4_out, 32'h10);

        // Jump from 0xC to 0x100; ack during REDIRECT must be ignored.
        jmp_valid = 1'b1;
        jmp_index = 26'h40;
        step();
        clear_redirects();
        check("jmp_addr", if_addr, 32'h100);
        check("jmp_flush", {31'h0, flush}, 32'h1);
        check("jmp_req", {31'h0, if_req}, 32'h0);
        step();
        check("jmp_hold", if_addr, 32'h100);
        check("jmp_flush_end", {31'h0, flush}, 32'h0);

        // Backward branch at 0x100: 0x104 + (-2 words) = 0xFC.
        take_branch(32'h104, 16'hFFFE);
        step();
        clear_redirects();
        check("br_addr", if_addr, 32'h0FC);
        check("br_flush", {31'h0, flush}, 32'h1);
        check("br_req", {31'h0, if_req}, 32'h0);
        step();
        check("br_flush_end", {31'h0, flush}, 32'h0);
        check("br_fetch_req", {31'h0, if_req}, 32'h1);
        check("br_fetch_addr", if_addr, 32'h0FC);

        // Not-taken branch is ignored; normal advance to 0x100.
        br_valid = 1'b1;
        br_taken = 1'b0;
        br_pc4   = 32'h8000;
        step();
        clear_redirects();
        check("nt_addr", if_addr, 32'h100);
        check("nt_flush", {31'h0, flush}, 32'h0);

        // Branch (0x200) and jump (0x300) together under stall with ack.
        stall = 1'b1;
        take_branch(32'h200, 16'h0);
        jmp_valid = 1'b1;
        jmp_index = 26'hC0;
        #1;
        check("both_req", {31'h0, if_req}, 32'h0);
        step();
        clear_redirects();
        stall = 1'b0;
        check("both_addr", if_addr, 32'h200);
        check("both_flush", {31'h0, flush}, 32'h1);
        step();
        check("both_single_flush", {31'h0, flush}, 32'h0);
        check("both_fetch_addr", if_addr, 32'h200);
        step();
        check("both_adv", if_addr, 32'h204);

        // Branch to 0x4000_0010, then a jump while in REDIRECT -> 0x4000_0100.
        take_branch(32'h4000_0010, 16'h0);
        step();
        clear_redirects();
        check("hi_addr", if_addr, 32'h4000_0010);
        jmp_valid = 1'b1;
        jmp_index = 26'h40;
        step();
        clear_redirects();
        check("rr_addr", if_addr, 32'h4000_0100);
        check("rr_flush", {31'h0, flush}, 32'h1);
        check("rr_req", {31'h0, if_req}, 32'h0);
        step();
        check("rr_flush_end", {31'h0, flush}, 32'h0);
        check("rr_fetch_req", {31'h0, if_req}, 32'h1);

        // Move to 0x20 and stall three cycles with ack asserted.
        take_branch(32'h20, 16'h0);
        step();
        clear_redirects();
        step();
        check("st_start", if_addr, 32'h20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_req", {31'h0, if_req}, 32'h0);
            step();
            check("st_addr", if_addr, 32'h20);
        end
        stall = 1'b0;
        #1;
        check("st_resume_req", {31'h0, if_req}, 32'h1);
        step();
        check("st_resume_addr", if_addr, 32'h24);

        // Wrap from 0xFFFF_FFFC to 0.
        take_branch(32'hFFFF_FFFC, 16'h0);
        step();
        clear_redirects();
        step();
        check("wrap_pre", if_addr, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_out, 32'h0);
        step();
        check("wrap_addr", if_addr, 32'h0);

        // Reset asserted mid-cycle during REDIRECT.
        jmp_valid = 1'b1;
        jmp_index = 26'h40;
        step();
        check("pre_rst_flush", {31'h0, flush}, 32'h1);
        check("pre_rst_addr", if_addr, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_addr", if_addr, 32'h0);
        check("async_flush", {31'h0, flush}, 32'h0);
        check("async_req", {31'h0, if_req}, 32'h0);
        step();
        clear_redirects();
        check("rst_hold_addr", if_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst2_init_req", {31'h0, if_req}, 32'h0);
        step();
        check("rst2_addr", if_addr, 32'h0);
        check("rst2_req", {31'h0, if_req}, 32'h1);
        check("rst2_flush", {31'h0, flush}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port stall, input, 1, pipeline hold request from hazard logic.
REQ-005 SHALL have port if_req, output, 1, instruction-fetch request to imem.
REQ-006 SHALL have port if_addr, output, 32, fetch address; always equal to the PC register.
REQ-007 SHALL have port if_ack, input, 1, imem accepted the request at if_addr this cycle.
REQ-008 SHALL have port pc4_out, output, 32, combinational PC+4 for the decode stage.
REQ-009 SHALL have port br_valid, input, 1, a conditional branch resolved this cycle.
REQ-010 SHALL have port br_taken, input, 1, branch outcome; ignored unless br_valid.
REQ-011 SHALL have port br_pc4, input, 32, PC+4 of the resolving branch.
REQ-012 SHALL have port br_imm, input, 16, branch word offset.
REQ-013 SHALL have port jmp_valid, input, 1, a J/JAL decoded this cycle.
REQ-014 SHALL have port jmp_index, input, 26, jump instruction index field.
REQ-015 SHALL have port flush, output, 1, registered one-cycle kill of younger in-flight instructions.

Function
REQ-016 SHALL hold a 3-state FSM: INIT, FETCH, REDIRECT.
REQ-017 SHALL compute branch target = br_pc4 + ({{14{br_imm[15]}}, br_imm, 2'b00}) modulo 2^32.
REQ-018 SHALL compute jump target = {pc[31:28] of (pc+4), jmp_index, 2'b00} using the current PC register.
REQ-019 SHALL, in INIT, drive if_req=0 and go to FETCH on the next edge; PC unchanged.
REQ-020 SHALL, in FETCH, drive if_req = ~stall.
REQ-021 SHALL, in FETCH with if_req=1 and if_ack=1 and no redirect, load PC <= PC+4 (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 SHALL, in FETCH with stall=1 or if_ack=0 and no redirect, hold PC; if_ack while stall=1 is ignored.
REQ-023 SHALL treat redirect = (br_valid & br_taken) | jmp_valid, evaluated in FETCH and REDIRECT, regardless of stall or if_ack.
REQ-024 SHALL give taken branch priority over jump when both occur in one cycle (branch is older).
REQ-025 SHALL, on redirect, load PC <= selected target, set flush=1 for the following cycle only, enter REDIRECT.
REQ-026 SHALL, in REDIRECT, drive if_req=0, ignore if_ack, and return to FETCH next edge unless a new redirect occurs.
REQ-027 SHALL, on redirect in REDIRECT, load the new target, keep flush=1 another cycle, remain in REDIRECT.
REQ-028 SHALL ignore br_valid with br_taken=0 (no PC change, no flush).
REQ-029 SHALL have latency: PC advance 1 cycle after ack; target visible on if_addr 1 cycle after redirect; fetch at target issued 2 cycles after redirect.

Reset
REQ-030 SHALL, while rst_n=0, force PC=RESET_PC, state=INIT, if_req=0, flush=0 immediately, independent of clk.
REQ-031 SHALL, on reset mid-operation (including during REDIRECT), discard any pending redirect and restart from INIT.
REQ-032 SHALL begin fetching at RESET_PC on the second rising edge after rst_n deasserts.

Verification
REQ-033 Reset release, if_ack=1 every cycle -> if_addr 0x0, 0x4, 0x8, 0xC; if_req low only in first cycle.
REQ-034 PC=0x100, br_valid=1, br_taken=1, br_pc4=0x104, br_imm=16'hFFFE -> next if_addr 0x0FC, flush=1 one cycle, if_req=0 that cycle.
REQ-035 PC=0x4000_0010, jmp_valid=1, jmp_index=26'h0000040 -> if_addr 0x4000_0100, flush pulse.
REQ-036 Same cycle taken branch (target 0x200) and jump (target 0x300), stall=1, if_ack=1 -> if_addr 0x200, single flush.
REQ-037 stall=1 for 3 cycles with if_ack=1 at PC=0x20 -> if_req=0, if_addr stays 0x20; resumes 0x24 after stall drops and ack.
REQ-038 PC=0xFFFF_FFFC acked -> if_addr 0x0000_0000; rst_n pulsed low during REDIRECT -> if_addr=RESET_PC, flush=0 asynchronously.
